// File: rtl/sig_checker_pkg.sv
// Shared types, constants and the signature step function for signature_checker.
// The optional midpoint snapshot is enabled by defining SIG_CHECKER_MIDPOINT_EN.
package sig_checker_pkg;

    localparam int SIG_W = 16;
    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] STIM_FULL = 8'hFF;
    localparam logic [CNT_W-1:0] STIM_MID  = 8'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Rotate left by one while replacing the low byte with (low byte + scrambled).
    function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                  input logic [7:0]       scrambled);
        logic [7:0] sum;
        sum = sig[7:0] + scrambled;
        return {sig[14:8], sum, sig[15]};
    endfunction

endpackage

// File: rtl/sig_scrambler.sv
// Combinational XOR fold of the core observation buses and the seed into one byte.
module sig_scrambler (
    input  logic [7:0] seed_i,
    input  logic [7:0] pc_i,
    input  logic [7:0] ir_i,
    input  logic [7:0] pm_address_i,
    input  logic [7:0] from_ps_i,
    input  logic [7:0] from_id_i,
    input  logic [7:0] from_cu_i,
    input  logic [3:0] x1_i,
    input  logic [3:0] y0_i,
    input  logic [3:0] y1_i,
    input  logic [3:0] r_i,
    input  logic       zero_flag_i,
    output logic [7:0] scrambled_o
);

    assign scrambled_o = seed_i ^ {x1_i, x1_i} ^ {y1_i, y0_i} ^ {3'b000, zero_flag_i, r_i}
                       ^ ir_i ^ pc_i ^ pm_address_i ^ from_ps_i ^ from_id_i ^ from_cu_i;

endmodule

// File: rtl/signature_checker.sv
// Signature compressor for processor self-test: drives i_pins stimulus, folds observations.
// Define SIG_CHECKER_MIDPOINT_EN to build the sig_mid snapshot register.
module signature_checker
    import sig_checker_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic [SIG_W-1:0] expected_sig,
    input  logic [7:0]       pc,
    input  logic [7:0]       ir,
    input  logic [7:0]       pm_address,
    input  logic [7:0]       from_ps,
    input  logic [7:0]       from_id,
    input  logic [7:0]       from_cu,
    input  logic [3:0]       x1,
    input  logic [3:0]       y0,
    input  logic [3:0]       y1,
    input  logic [3:0]       r,
    input  logic             zero_flag,
    output logic [CNT_W-1:0] stimulus,
    output logic [SIG_W-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig_mid
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stim_q, stim_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             pass_q, pass_d;
    logic [7:0]       scrambled;
    logic             run_start;

    sig_scrambler u_scrambler (
        .seed_i       (seed),
        .pc_i         (pc),
        .ir_i         (ir),
        .pm_address_i (pm_address),
        .from_ps_i    (from_ps),
        .from_id_i    (from_id),
        .from_cu_i    (from_cu),
        .x1_i         (x1),
        .y0_i         (y0),
        .y1_i         (y1),
        .r_i          (r),
        .zero_flag_i  (zero_flag),
        .scrambled_o  (scrambled)
    );

    assign run_start = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    stim_d  = '0;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                // The final counter value ends the run without a further update.
                if (stim_q != STIM_FULL) begin
                    stim_d = stim_q + CNT_W'(1);
                    sig_d  = sig_step(sig_q, scrambled);
                end else begin
                    pass_d  = (sig_q == expected_sig);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stim_q  <= '0;
            sig_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

`ifdef SIG_CHECKER_MIDPOINT_EN
    logic [SIG_W-1:0] mid_q;

    // Snapshot holds the signature produced by the 128th update.
    always_ff @(posedge clk) begin
        if (reset) begin
            mid_q <= '0;
        end else if (run_start) begin
            mid_q <= '0;
        end else if (state_q == RUN && stim_q == STIM_MID) begin
            mid_q <= sig_d;
        end
    end

    assign sig_mid = mid_q;
`else
    assign sig_mid = '0;
`endif

    assign stimulus = stim_q;
    assign sig      = sig_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;

endmodule
